// File: rtl/ut_ctrl_fsm.sv
// Control sequencer for the 6-bit accumulator processor.
// Fetch/decode/execute FSM driving PC, RI, ALU, carry and memory strobes.
module ut_ctrl_fsm #(
    parameter int unsigned INIT_CYCLES   = 1,
    parameter bit          JCC_CLR_CARRY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [1:0] opcode,
    input  logic       carry,
    output logic       clear_PC,
    output logic       load_PC,
    output logic       enable_PC,
    output logic       load_RI,
    output logic       sel_UAL,
    output logic       enable_mem,
    output logic       rw_mem,
    output logic       load_ACC,
    output logic       sel_ADD,
    output logic       load_carry,
    output logic       init_carry,
    output logic       instr_done,
    output logic [2:0] state_dbg
);

    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        FETCH_INS = 3'd1,
        LOAD_RI   = 3'd2,
        DECODE    = 3'd3,
        FETCH_OP  = 3'd4,
        EXE_UAL   = 3'd5,
        STA       = 3'd6,
        JCC       = 3'd7
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] init_cnt;
    logic             active;

    // State register and transitions; ce=0 freezes both state and INIT counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else if (ce) begin
            case (state)
                INIT: begin
                    if (init_cnt >= INIT_LAST) begin
                        state    <= FETCH_INS;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + CNT_W'(1);
                    end
                end
                FETCH_INS: state <= LOAD_RI;
                LOAD_RI:   state <= DECODE;
                DECODE: begin
                    case (opcode)
                        2'b10:   state <= STA;
                        2'b11:   state <= JCC;
                        default: state <= FETCH_OP;
                    endcase
                end
                FETCH_OP:  state <= EXE_UAL;
                EXE_UAL:   state <= FETCH_INS;
                STA:       state <= FETCH_INS;
                JCC:       state <= FETCH_INS;
                default:   state <= INIT;
            endcase
        end
    end

    // Strobes are forced low while reset is asserted so an aborted STA never writes
    assign active    = ce & ~rst;
    assign state_dbg = state;

    // Per-state strobe decode
    always_comb begin
        clear_PC   = 1'b0;
        load_PC    = 1'b0;
        enable_PC  = 1'b0;
        load_RI    = 1'b0;
        sel_UAL    = 1'b0;
        enable_mem = 1'b0;
        rw_mem     = 1'b0;
        load_ACC   = 1'b0;
        sel_ADD    = 1'b0;
        load_carry = 1'b0;
        init_carry = 1'b0;
        instr_done = 1'b0;
        if (active) begin
            case (state)
                INIT: begin
                    clear_PC   = 1'b1;
                    enable_PC  = 1'b1;
                    init_carry = 1'b1;
                end
                FETCH_INS: begin
                    enable_mem = 1'b1;
                end
                LOAD_RI: begin
                    load_RI = 1'b1;
                end
                DECODE: begin
                    enable_PC = 1'b1;
                end
                FETCH_OP: begin
                    enable_mem = 1'b1;
                    sel_UAL    = 1'b1;
                end
                EXE_UAL: begin
                    load_ACC   = 1'b1;
                    sel_ADD    = opcode[0];
                    load_carry = (opcode == 2'b01);
                    instr_done = 1'b1;
                end
                STA: begin
                    enable_mem = 1'b1;
                    rw_mem     = 1'b1;
                    sel_UAL    = 1'b1;
                    instr_done = 1'b1;
                end
                JCC: begin
                    // Jump when carry is clear; otherwise optionally consume the carry
                    load_PC    = ~carry;
                    init_carry = carry & JCC_CLR_CARRY;
                    instr_done = 1'b1;
                end
                default: begin
                    clear_PC = 1'b0;
                end
            endcase
        end
    end

endmodule
